// File: rtl/plateau_detector_gen.sv
`default_nettype none
// ============================================================================
//  Module      : plateau_detector_gen
//  Description : OFDM frame-sync plateau detector. Watches a correlation
//                metric stream and a phase stream in lockstep, finds a rising
//                edge, a settled peak and a sustained plateau, then counts a
//                programmable delay and emits a one-beat frame-start pulse
//                on o_tlast. The phase at the settled peak is latched and
//                presented on o_tdata for downstream CFO correction.
//
//  Ports       : clk, reset (async, active-high), clear (sync)
//                threshold / plateau_len / trigger_delay : runtime settings,
//                    sampled only while idle
//                i0_* : metric stream     i1_* : phase stream
//                o_*  : latched phase + frame-start pulse (tlast)
//                det_count : triggers since reset/clear, wraps
//
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module plateau_detector_gen #(
    parameter int WIDTH       = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int EDGE_MARGIN = 100,
    parameter int SETTLE_LEN  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       threshold,
    input  logic [CNT_WIDTH-1:0]   plateau_len,
    input  logic [CNT_WIDTH-1:0]   trigger_delay,
    input  logic [WIDTH-1:0]       i0_tdata,
    input  logic                   i0_tvalid,
    output logic                   i0_tready,
    input  logic                   i0_tlast,
    input  logic [PHASE_WIDTH-1:0] i1_tdata,
    input  logic                   i1_tvalid,
    output logic                   i1_tready,
    input  logic                   i1_tlast,
    output logic [PHASE_WIDTH-1:0] o_tdata,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic                   o_tlast,
    output logic [15:0]            det_count
);

    // Settle counter only has to reach SETTLE_LEN; +2 keeps the width >= 1.
    localparam int                 c_SETTLE_W    = $clog2(SETTLE_LEN + 2);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_LEN);
    localparam logic [WIDTH:0]     c_MARGIN      = (WIDTH + 1)'(EDGE_MARGIN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_SETTLE  = 3'd2,
        S_PLATEAU = 3'd3,
        S_DELAY   = 3'd4
    } state_t;

    state_t                 r_state,       w_state_nxt;
    logic [WIDTH-1:0]       r_max_val,     w_max_val_nxt;
    logic [PHASE_WIDTH-1:0] r_max_phase,   w_max_phase_nxt;
    logic [CNT_WIDTH-1:0]   r_plen_cnt,    w_plen_cnt_nxt;
    logic [c_SETTLE_W-1:0]  r_settle_cnt,  w_settle_cnt_nxt;
    logic [CNT_WIDTH-1:0]   r_dly_cnt,     w_dly_cnt_nxt;
    logic                   r_trigger,     w_trigger_nxt;
    logic [15:0]            r_det_count,   w_det_count_nxt;
    logic [WIDTH-1:0]       r_thr_s,       w_thr_s_nxt;
    logic [CNT_WIDTH-1:0]   r_plen_s,      w_plen_s_nxt;
    logic [CNT_WIDTH-1:0]   r_dly_s,       w_dly_s_nxt;

    logic                   w_beat;
    logic [WIDTH-1:0]       w_thr_eff;
    logic                   w_met;
    logic                   w_rising;
    logic [CNT_WIDTH-1:0]   w_plen_inc;
    logic                   w_unused;

    // tlast on both inputs carries no meaning for detection.
    assign w_unused = i0_tlast ^ i1_tlast;

    // Ready depends on o_tready but valid never depends on ready.
    assign w_beat    = i0_tvalid & i1_tvalid & o_tready;
    assign o_tvalid  = i0_tvalid & i1_tvalid;
    assign i0_tready = w_beat;
    assign i1_tready = w_beat;

    // While idle the live threshold applies, so the entry beat and the
    // shadow register see the same value.
    assign w_thr_eff = (r_state == S_IDLE) ? threshold : r_thr_s;
    assign w_met     = i0_tdata > w_thr_eff;
    // One extra bit so max_val + margin cannot wrap near full scale.
    assign w_rising  = {1'b0, i0_tdata} > ({1'b0, r_max_val} + c_MARGIN);
    assign w_plen_inc = (&r_plen_cnt) ? r_plen_cnt : r_plen_cnt + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_max_val_nxt    = r_max_val;
        w_max_phase_nxt  = r_max_phase;
        w_plen_cnt_nxt   = r_plen_cnt;
        w_settle_cnt_nxt = r_settle_cnt;
        w_dly_cnt_nxt    = r_dly_cnt;
        w_trigger_nxt    = 1'b0;
        w_det_count_nxt  = r_det_count;
        w_thr_s_nxt      = r_thr_s;
        w_plen_s_nxt     = r_plen_s;
        w_dly_s_nxt      = r_dly_s;

        case (r_state)
            S_IDLE: begin
                w_thr_s_nxt  = threshold;
                w_plen_s_nxt = plateau_len;
                w_dly_s_nxt  = trigger_delay;
                if (w_met) begin
                    w_state_nxt      = S_RISE;
                    w_max_val_nxt    = i0_tdata;
                    w_plen_cnt_nxt   = CNT_WIDTH'(1);
                    w_settle_cnt_nxt = '0;
                end
            end

            S_RISE: begin
                if (!w_met) begin
                    w_state_nxt      = S_IDLE;
                    w_plen_cnt_nxt   = '0;
                    w_settle_cnt_nxt = '0;
                    w_dly_cnt_nxt    = '0;
                end else begin
                    w_plen_cnt_nxt = w_plen_inc;
                    if (w_rising) begin
                        w_max_val_nxt = i0_tdata;
                    end else begin
                        w_state_nxt = S_SETTLE;
                    end
                end
            end

            S_SETTLE: begin
                if (!w_met) begin
                    w_state_nxt      = S_IDLE;
                    w_plen_cnt_nxt   = '0;
                    w_settle_cnt_nxt = '0;
                    w_dly_cnt_nxt    = '0;
                end else begin
                    w_plen_cnt_nxt = w_plen_inc;
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        w_max_phase_nxt = i1_tdata;
                        w_state_nxt     = S_PLATEAU;
                    end else if (w_rising) begin
                        w_max_val_nxt    = i0_tdata;
                        w_settle_cnt_nxt = '0;
                        w_state_nxt      = S_RISE;
                    end else begin
                        w_settle_cnt_nxt = r_settle_cnt + 1'b1;
                    end
                end
            end

            S_PLATEAU: begin
                if (!w_met) begin
                    w_state_nxt      = S_IDLE;
                    w_plen_cnt_nxt   = '0;
                    w_settle_cnt_nxt = '0;
                    w_dly_cnt_nxt    = '0;
                end else begin
                    w_plen_cnt_nxt = w_plen_inc;
                    if (r_plen_cnt > r_plen_s) begin
                        w_state_nxt   = S_DELAY;
                        w_dly_cnt_nxt = '0;
                    end
                end
            end

            S_DELAY: begin
                // Metric is deliberately ignored once the plateau is accepted.
                if (r_dly_cnt == r_dly_s) begin
                    w_trigger_nxt    = 1'b1;
                    w_det_count_nxt  = r_det_count + 16'd1;
                    w_state_nxt      = S_IDLE;
                    w_plen_cnt_nxt   = '0;
                    w_settle_cnt_nxt = '0;
                    w_dly_cnt_nxt    = '0;
                end else begin
                    w_dly_cnt_nxt = r_dly_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt      = S_IDLE;
                w_plen_cnt_nxt   = '0;
                w_settle_cnt_nxt = '0;
                w_dly_cnt_nxt    = '0;
            end
        endcase
    end

    // Everything, including the trigger, advances only on a beat so a
    // stalled output holds o_tlast until downstream takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_max_val    <= '0;
            r_max_phase  <= '0;
            r_plen_cnt   <= '0;
            r_settle_cnt <= '0;
            r_dly_cnt    <= '0;
            r_trigger    <= 1'b0;
            r_det_count  <= '0;
            r_thr_s      <= '0;
            r_plen_s     <= '0;
            r_dly_s      <= '0;
        end else if (clear) begin
            r_state      <= S_IDLE;
            r_max_val    <= '0;
            r_max_phase  <= '0;
            r_plen_cnt   <= '0;
            r_settle_cnt <= '0;
            r_dly_cnt    <= '0;
            r_trigger    <= 1'b0;
            r_det_count  <= '0;
            r_thr_s      <= '0;
            r_plen_s     <= '0;
            r_dly_s      <= '0;
        end else if (w_beat) begin
            r_state      <= w_state_nxt;
            r_max_val    <= w_max_val_nxt;
            r_max_phase  <= w_max_phase_nxt;
            r_plen_cnt   <= w_plen_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_dly_cnt    <= w_dly_cnt_nxt;
            r_trigger    <= w_trigger_nxt;
            r_det_count  <= w_det_count_nxt;
            r_thr_s      <= w_thr_s_nxt;
            r_plen_s     <= w_plen_s_nxt;
            r_dly_s      <= w_dly_s_nxt;
        end
    end

    assign o_tdata   = r_max_phase;
    assign o_tlast   = r_trigger;
    assign det_count = r_det_count;

endmodule
`default_nettype wire

// File: tb/tb_plateau_detector_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plateau_detector_gen
//  Description : Self-checking bench for plateau_detector_gen. Traces are
//                built as beat-indexed arrays, a behavioural model walks each
//                trace phase by phase (wait, climb/settle, plateau, delay) to
//                predict per-beat outputs, and each test compares the
//                beat-indexed DUT outputs against those predictions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plateau_detector_gen;

    localparam int c_N      = 1024;
    localparam int c_MARGIN = 100;
    localparam int c_SETTLE = 3;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [15:0] threshold;
    logic [15:0] plateau_len;
    logic [15:0] trigger_delay;
    logic [15:0] i0_tdata;
    logic        i0_tvalid;
    logic        i0_tready;
    logic        i0_tlast;
    logic [15:0] i1_tdata;
    logic        i1_tvalid;
    logic        i1_tready;
    logic        i1_tlast;
    logic [15:0] o_tdata;
    logic        o_tvalid;
    logic        o_tready;
    logic        o_tlast;
    logic [15:0] det_count;

    plateau_detector_gen dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .threshold     (threshold),
        .plateau_len   (plateau_len),
        .trigger_delay (trigger_delay),
        .i0_tdata      (i0_tdata),
        .i0_tvalid     (i0_tvalid),
        .i0_tready     (i0_tready),
        .i0_tlast      (i0_tlast),
        .i1_tdata      (i1_tdata),
        .i1_tvalid     (i1_tvalid),
        .i1_tready     (i1_tready),
        .i1_tlast      (i1_tlast),
        .o_tdata       (o_tdata),
        .o_tvalid      (o_tvalid),
        .o_tready      (o_tready),
        .o_tlast       (o_tlast),
        .det_count     (det_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Trace description (inputs per beat index)
    int m   [c_N];
    int p   [c_N];
    int thr [c_N];
    int pln [c_N];
    int dly [c_N];
    int cur_thr, cur_pl, cur_dl;

    // Predicted and observed outputs after each beat
    logic [15:0] exp_tdata [c_N];
    logic        exp_tlast [c_N];
    logic [15:0] exp_det   [c_N];
    logic [15:0] obs_tdata [c_N];
    logic        obs_tlast [c_N];
    logic [15:0] obs_det   [c_N];

    int hs_bad, hold_bad;
    bit timed_out;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic fill(input int start, input int cnt, input int val);
        for (int k = start; k < start + cnt; k++) begin
            m[k] = val; p[k] = k; thr[k] = cur_thr; pln[k] = cur_pl; dly[k] = cur_dl;
        end
    endtask

    function automatic void put(input int i, input int ph, input bit t, input int det);
        exp_tdata[i] = 16'(ph);
        exp_tlast[i] = t;
        exp_det[i]   = 16'(det);
    endfunction

    // Reference: walk the trace as a sequence of detection attempts.
    task automatic build_model(input int n);
        int i, t, pl, dl, mx, cnt, sc, d, ph, det;
        bit aborted, climbing;
        ph = 0; det = 0; i = 0;
        while (i < n) begin
            if (m[i] <= thr[i]) begin put(i, ph, 0, det); i++; continue; end
            t = thr[i]; pl = pln[i]; dl = dly[i]; mx = m[i]; cnt = 1;
            put(i, ph, 0, det); i++;
            // climb towards the peak, then require SETTLE quiet beats
            aborted = 1; climbing = 1; sc = 0;
            while (i < n) begin
                if (m[i] <= t) begin put(i, ph, 0, det); i++; break; end
                cnt = (cnt < 65535) ? cnt + 1 : cnt;
                if (!climbing && sc == c_SETTLE) begin
                    ph = p[i]; put(i, ph, 0, det); i++; aborted = 0; break;
                end
                if (m[i] > mx + c_MARGIN) begin mx = m[i]; climbing = 1; sc = 0; end
                else if (climbing) climbing = 0;
                else sc++;
                put(i, ph, 0, det); i++;
            end
            if (aborted) continue;
            // plateau must outlast the requested length
            aborted = 1;
            while (i < n) begin
                if (m[i] <= t) begin put(i, ph, 0, det); i++; break; end
                if (cnt > pl) begin put(i, ph, 0, det); i++; aborted = 0; break; end
                cnt = (cnt < 65535) ? cnt + 1 : cnt;
                put(i, ph, 0, det); i++;
            end
            if (aborted) continue;
            // fixed delay regardless of metric
            d = 0;
            while (i < n) begin
                if (d == dl) begin
                    det = (det + 1) & 16'hFFFF; put(i, ph, 1, det); i++; break;
                end
                d++; put(i, ph, 0, det); i++;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        i0_tvalid = 1'b0; i1_tvalid = 1'b0; o_tready = 1'b1; clear = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives a trace beat by beat and records the DUT outputs per beat.
    task automatic drive_trace(input int n, input bit stall);
        int k, cycles;
        logic fire, pl_last;
        logic [15:0] pl_data, pl_det;
        k = 0; cycles = 0; hs_bad = 0; hold_bad = 0; timed_out = 0;
        while (k < n) begin
            if (cycles > n * 8 + 100) begin timed_out = 1; break; end
            @(negedge clk);
            i0_tdata = 16'(m[k]); i1_tdata = 16'(p[k]);
            threshold = 16'(thr[k]); plateau_len = 16'(pln[k]); trigger_delay = 16'(dly[k]);
            i0_tlast = 1'($urandom_range(0, 1)); i1_tlast = 1'($urandom_range(0, 1));
            if (stall) begin
                i0_tvalid = ($urandom_range(0, 3) != 0);
                i1_tvalid = ($urandom_range(0, 3) != 0);
                o_tready  = 1'($urandom_range(0, 1));
            end else begin
                i0_tvalid = 1'b1; i1_tvalid = 1'b1; o_tready = 1'b1;
            end
            #1;
            fire = i0_tvalid & i1_tvalid & o_tready;
            if (o_tvalid !== (i0_tvalid & i1_tvalid) || i0_tready !== fire || i1_tready !== fire)
                hs_bad++;
            pl_last = o_tlast; pl_data = o_tdata; pl_det = det_count;
            @(posedge clk);
            #1;
            if (fire) begin
                obs_tdata[k] = o_tdata; obs_tlast[k] = o_tlast; obs_det[k] = det_count;
                k++;
            end else if (o_tlast !== pl_last || o_tdata !== pl_data || det_count !== pl_det) begin
                hold_bad++;
            end
            cycles++;
        end
        @(negedge clk);
        i0_tvalid = 1'b0; i1_tvalid = 1'b0; o_tready = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        tests++;
        if (o_tdata !== 16'd0 || o_tlast !== 1'b0 || det_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_outputs: got tdata=%0d tlast=%0b det=%0d, required 0/0/0", o_tdata, o_tlast, det_count);
        end
        tests++;
        if (o_tvalid !== 1'b0 || i0_tready !== 1'b0 || i1_tready !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: got valid=%0b rdy0=%0b rdy1=%0b, required 0", o_tvalid, i0_tready, i1_tready);
        end
    endtask

    task automatic build_nominal();
        cur_thr = 1; cur_pl = 90; cur_dl = 128;
        fill(0, 10, 0);
        fill(10, 1, 200); fill(11, 1, 400); fill(12, 1, 600); fill(13, 1, 800);
        fill(14, 200, 850);
        fill(214, 40, 0);
        build_model(254);
    endtask

    task automatic test_nominal(input bit stall, input string tag);
        int pulses;
        apply_reset();
        build_nominal();
        drive_trace(254, stall);
        tests++;
        if (timed_out || hs_bad != 0 || hold_bad != 0) begin
            fails++;
            $display("FAIL %s_protocol: got timeout=%0b hs_err=%0d hold_err=%0d, required 0/0/0", tag, timed_out, hs_bad, hold_bad);
        end
        for (int k = 0; k < 254; k++) begin
            tests++;
            if (obs_tdata[k] !== exp_tdata[k] || obs_tlast[k] !== exp_tlast[k] || obs_det[k] !== exp_det[k]) begin
                fails++;
                $display("FAIL %s beat %0d: got tdata=%0d tlast=%0b det=%0d, required %0d/%0b/%0d",
                         tag, k, obs_tdata[k], obs_tlast[k], obs_det[k], exp_tdata[k], exp_tlast[k], exp_det[k]);
            end
        end
        pulses = 0;
        for (int k = 0; k < 254; k++) if (obs_tlast[k] === 1'b1) pulses++;
        tests++;
        if (pulses != 1 || obs_tlast[230] !== 1'b1 || obs_tdata[230] !== 16'd18 || obs_det[253] !== 16'd1) begin
            fails++;
            $display("FAIL %s_pulse: got pulses=%0d tlast@230=%0b phase=%0d det=%0d, required 1/1/18/1",
                     tag, pulses, obs_tlast[230], obs_tdata[230], obs_det[253]);
        end
    endtask

    task automatic test_plateau_drop();
        int pulses;
        apply_reset();
        cur_thr = 1; cur_pl = 90; cur_dl = 128;
        fill(0, 10, 0);
        fill(10, 1, 200); fill(11, 1, 400); fill(12, 1, 600); fill(13, 1, 800);
        fill(14, 54, 850);
        fill(68, 82, 0);
        build_model(150);
        drive_trace(150, 0);
        pulses = 0;
        for (int k = 0; k < 150; k++) begin
            tests++;
            if (obs_tdata[k] !== exp_tdata[k] || obs_tlast[k] !== exp_tlast[k] || obs_det[k] !== exp_det[k]) begin
                fails++;
                $display("FAIL drop beat %0d: got tdata=%0d tlast=%0b det=%0d, required %0d/%0b/%0d",
                         k, obs_tdata[k], obs_tlast[k], obs_det[k], exp_tdata[k], exp_tlast[k], exp_det[k]);
            end
            if (obs_tlast[k] === 1'b1) pulses++;
        end
        tests++;
        if (timed_out || pulses != 0 || obs_det[149] !== 16'd0) begin
            fails++;
            $display("FAIL drop_no_trigger: got timeout=%0b pulses=%0d det=%0d, required 0/0/0", timed_out, pulses, obs_det[149]);
        end
    endtask

    task automatic test_settle_jump();
        apply_reset();
        cur_thr = 1; cur_pl = 90; cur_dl = 5;
        fill(0, 10, 0);
        fill(10, 1, 200); fill(11, 1, 400); fill(12, 1, 600); fill(13, 1, 800);
        fill(14, 2, 850);
        fill(16, 150, 1000);
        fill(166, 60, 0);
        build_model(226);
        drive_trace(226, 0);
        for (int k = 0; k < 226; k++) begin
            tests++;
            if (obs_tdata[k] !== exp_tdata[k] || obs_tlast[k] !== exp_tlast[k] || obs_det[k] !== exp_det[k]) begin
                fails++;
                $display("FAIL settle_jump beat %0d: got tdata=%0d tlast=%0b det=%0d, required %0d/%0b/%0d",
                         k, obs_tdata[k], obs_tlast[k], obs_det[k], exp_tdata[k], exp_tlast[k], exp_det[k]);
            end
        end
        tests++;
        if (timed_out || obs_tdata[20] !== 16'd0 || obs_tdata[21] !== 16'd21 || obs_tlast[107] !== 1'b1) begin
            fails++;
            $display("FAIL settle_jump_latch: got phase@20=%0d phase@21=%0d tlast@107=%0b, required 0/21/1",
                     obs_tdata[20], obs_tdata[21], obs_tlast[107]);
        end
    endtask

    task automatic test_top_of_range();
        apply_reset();
        cur_thr = 1; cur_pl = 5; cur_dl = 3;
        fill(0, 5, 0); fill(5, 1, 65500); fill(6, 30, 65535); fill(36, 10, 0);
        build_model(46);
        drive_trace(46, 0);
        for (int k = 0; k < 46; k++) begin
            tests++;
            if (obs_tdata[k] !== exp_tdata[k] || obs_tlast[k] !== exp_tlast[k] || obs_det[k] !== exp_det[k]) begin
                fails++;
                $display("FAIL top_range beat %0d: got tdata=%0d tlast=%0b det=%0d, required %0d/%0b/%0d",
                         k, obs_tdata[k], obs_tlast[k], obs_det[k], exp_tdata[k], exp_tlast[k], exp_det[k]);
            end
        end
        tests++;
        if (timed_out || obs_tdata[10] !== 16'd10 || obs_tlast[15] !== 1'b1) begin
            fails++;
            $display("FAIL top_range_nowrap: got phase@10=%0d tlast@15=%0b, required 10/1", obs_tdata[10], obs_tlast[15]);
        end
    endtask

    task automatic test_random();
        int k, len, lvl;
        apply_reset();
        k = 0;
        while (k < 800) begin
            len = $urandom_range(5, 40);
            lvl = $urandom_range(0, 1200);
            for (int j = 0; j < len && k < 800; j++) begin
                m[k]   = lvl + $urandom_range(0, 120);
                p[k]   = $urandom_range(0, 65535);
                thr[k] = $urandom_range(200, 400);
                pln[k] = $urandom_range(0, 15);
                dly[k] = $urandom_range(0, 8);
                k++;
            end
        end
        build_model(800);
        drive_trace(800, 1);
        tests++;
        if (timed_out || hs_bad != 0 || hold_bad != 0) begin
            fails++;
            $display("FAIL random_protocol: got timeout=%0b hs_err=%0d hold_err=%0d, required 0/0/0", timed_out, hs_bad, hold_bad);
        end
        for (int b = 0; b < 800; b++) begin
            tests++;
            if (obs_tdata[b] !== exp_tdata[b] || obs_tlast[b] !== exp_tlast[b] || obs_det[b] !== exp_det[b]) begin
                fails++;
                $display("FAIL random beat %0d: got tdata=%0d tlast=%0b det=%0d, required %0d/%0b/%0d",
                         b, obs_tdata[b], obs_tlast[b], obs_det[b], exp_tdata[b], exp_tlast[b], exp_det[b]);
            end
        end
    endtask

    task automatic test_zero_delay_and_async_reset();
        int pulses;
        apply_reset();
        cur_thr = 1; cur_pl = 5; cur_dl = 0;
        fill(0, 3, 0); fill(3, 20, 500); fill(23, 10, 0);
        cur_dl = 40;
        fill(33, 30, 500); fill(63, 50, 0);
        build_model(113);
        drive_trace(60, 0);
        for (int k = 0; k < 60; k++) begin
            tests++;
            if (obs_tdata[k] !== exp_tdata[k] || obs_tlast[k] !== exp_tlast[k] || obs_det[k] !== exp_det[k]) begin
                fails++;
                $display("FAIL zero_delay beat %0d: got tdata=%0d tlast=%0b det=%0d, required %0d/%0b/%0d",
                         k, obs_tdata[k], obs_tlast[k], obs_det[k], exp_tdata[k], exp_tlast[k], exp_det[k]);
            end
        end
        tests++;
        if (timed_out || obs_tlast[9] !== 1'b0 || obs_tlast[10] !== 1'b1 || obs_det[59] !== 16'd2) begin
            fails++;
            $display("FAIL zero_delay_first_beat: got tlast@9=%0b tlast@10=%0b det=%0d, required 0/1/2",
                     obs_tlast[9], obs_tlast[10], obs_det[59]);
        end
        // Mid-DELAY: assert reset between clock edges and look before any edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (o_tdata !== 16'd0 || o_tlast !== 1'b0 || det_count !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: got tdata=%0d tlast=%0b det=%0d, required 0/0/0", o_tdata, o_tlast, det_count);
        end
        @(negedge clk);
        reset = 1'b0;
        cur_thr = 1; cur_pl = 5; cur_dl = 40;
        fill(0, 100, 0);
        build_model(100);
        drive_trace(100, 0);
        pulses = 0;
        for (int k = 0; k < 100; k++) if (obs_tlast[k] !== 1'b0 || obs_det[k] !== 16'd0) pulses++;
        tests++;
        if (timed_out || pulses != 0) begin
            fails++;
            $display("FAIL reset_abandons: got %0d beats with trigger/count, required 0", pulses);
        end
    endtask

    task automatic test_clear();
        apply_reset();
        cur_thr = 1; cur_pl = 2; cur_dl = 1;
        fill(0, 3, 0); fill(3, 12, 700); fill(15, 20, 0);
        build_model(35);
        drive_trace(35, 0);
        for (int k = 0; k < 35; k++) begin
            tests++;
            if (obs_tdata[k] !== exp_tdata[k] || obs_tlast[k] !== exp_tlast[k] || obs_det[k] !== exp_det[k]) begin
                fails++;
                $display("FAIL clear_pre beat %0d: got tdata=%0d tlast=%0b det=%0d, required %0d/%0b/%0d",
                         k, obs_tdata[k], obs_tlast[k], obs_det[k], exp_tdata[k], exp_tlast[k], exp_det[k]);
            end
        end
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (o_tdata !== 16'd0 || o_tlast !== 1'b0 || det_count !== 16'd0) begin
            fails++;
            $display("FAIL sync_clear: got tdata=%0d tlast=%0b det=%0d, required 0/0/0", o_tdata, o_tlast, det_count);
        end
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0;
        threshold = '0; plateau_len = '0; trigger_delay = '0;
        i0_tdata = '0; i0_tvalid = 1'b0; i0_tlast = 1'b0;
        i1_tdata = '0; i1_tvalid = 1'b0; i1_tlast = 1'b0;
        o_tready = 1'b1;

        test_reset();
        test_nominal(1'b0, "nominal");
        test_plateau_drop();
        test_settle_jump();
        test_top_of_range();
        test_nominal(1'b1, "backpressure");
        test_random();
        test_zero_delay_and_async_reset();
        test_clear();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plateau_detector_gen.md
Name: plateau_detector_gen

Overview:
- Parametrised successor to the fixed 16-bit plateau detector used in OFDM frame sync.
- Watches a correlation-metric stream M(d) and a phase stream in lockstep. Finds a rising edge, a settled peak and a sustained plateau, then counts a programmable delay and flags frame start.
- Latched phase goes downstream for CFO correction.
- New over the previous generation:
  - widths and margins are parameters;
  - threshold, plateau length and trigger delay are runtime inputs, shadowed per detection;
  - overflow-safe compares;
  - single-beat trigger pulse;
  - detection counter.

Parameters:
- WIDTH, 16, metric width (unsigned).
- PHASE_WIDTH, 16, phase sample width (passed through unsigned, not interpreted).
- CNT_WIDTH, 16, width of plateau/delay counters and runtime length inputs.
- EDGE_MARGIN, 100, metric increase that counts as still rising.
- SETTLE_LEN, 3, consecutive non-rising beats needed to accept the peak.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear; same effect as reset, lower priority
- threshold  in  WIDTH  metric must be strictly greater to be "met"
- plateau_len  in  CNT_WIDTH  minimum plateau length in beats
- trigger_delay  in  CNT_WIDTH  beats from plateau end to trigger
- i0_tdata  in  WIDTH  metric
- i0_tvalid  in  1  metric valid
- i0_tready  out  1  metric ready
- i0_tlast  in  1  ignored
- i1_tdata  in  PHASE_WIDTH  phase
- i1_tvalid  in  1  phase valid
- i1_tready  out  1  phase ready
- i1_tlast  in  1  ignored
- o_tdata  out  PHASE_WIDTH  latched peak phase
- o_tvalid  out  1  output valid
- o_tready  in  1  downstream ready
- o_tlast  out  1  frame-start trigger pulse
- det_count  out  16  number of triggers since reset/clear; wraps

Behaviour:
- Handshake:
  - beat = i0_tvalid & i1_tvalid & o_tready;
  - o_tvalid = i0_tvalid & i1_tvalid;
  - i0_tready = i1_tready = beat.
  - Combinational; no valid-to-ready loop through o_tready.
  - Exactly one output beat per input beat pair.
  - State changes only on a beat.
- Reset/clear:
  - state=IDLE; max_val, max_phase, all counters, trigger, det_count = 0.
  - Shadowed settings = 0.
  - o_tdata=0, o_tlast=0.
  - Reset/clear mid-detection abandons the detection with no trigger.
- Definitions:
  - met = i0_tdata > thr_s (thr_s = threshold while in IDLE).
  - rising = i0_tdata > max_val + EDGE_MARGIN.
  - Sum computed in WIDTH+1 bits; no wrap.
- States:
  - IDLE:
    - Settings shadowed every beat.
    - On beat with met -> RISE; max_val <= i0_tdata; plen_cnt <= 1; settle_cnt <= 0.
  - RISE:
    - plen_cnt++.
    - !met -> IDLE, zero counters.
    - Else if rising: max_val <= i0_tdata, stay.
    - Else -> SETTLE.
  - SETTLE:
    - plen_cnt++.
    - !met -> IDLE.
    - Else if settle_cnt == SETTLE_LEN: max_phase <= i1_tdata; -> PLATEAU.
    - Else if rising: max_val <= i0_tdata; settle_cnt <= 0; -> RISE.
    - Else settle_cnt++.
  - PLATEAU:
    - plen_cnt++ (saturating at all-ones).
    - !met -> IDLE, zero counters.
    - Else if plen_cnt > plen_s: -> DELAY; dly_cnt <= 0.
  - DELAY:
    - Metric ignored.
    - If dly_cnt == dly_s: trigger <= 1; det_count++; -> IDLE; counters zeroed.
    - Else dly_cnt++.
    - dly_s=0 triggers on the first DELAY beat.
- Output:
  - o_tdata = max_phase (registered, held until next latch).
  - o_tlast = trigger.
  - trigger clears on the next beat, so it is high for exactly one output beat: the one after the triggering beat.
  - Stalls (no beat) hold trigger and o_tlast.
- Runtime settings:
  - threshold, plateau_len and trigger_delay are sampled only in IDLE.
  - Changes during a detection take effect at the next detection.
- Same-beat trigger and re-detect: the trigger beat returns to IDLE, and the next beat may re-enter RISE.

Test Plan:
- Defaults, threshold=1, plateau_len=90, trigger_delay=128. Metric 0 x10, ramp 200,400,600,800, then 850 flat for 200 beats. Phase = beat index. -> max_phase latched on 4th settled beat; o_tlast one beat at the calculated index; det_count=1.
- Metric drops to 0 at plateau beat 50, plateau_len=90. -> return to IDLE; no o_tlast; det_count=0.
- In SETTLE, metric jumps from 850 to 1000. -> back to RISE; max_val=1000; phase latched later.
- WIDTH=16, metric 65500 with EDGE_MARGIN=100. -> no wrap; 65535 is not rising.
- o_tready toggled 50% random during scenario 1. -> identical beat-indexed output; o_tlast held across stalls; one pulse.
- trigger_delay=0, and reset asserted mid-DELAY. -> trigger on first DELAY beat; async reset zeroes all outputs without a clock edge.
